// File: rtl/wash_pkg.sv
// Shared types and tables for the wash sequencer: state encoding, prices,
// per-mode phase durations and a small binary-to-BCD helper.
package wash_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    WASH   = 3'd2,
    RINSE  = 3'd3,
    SPIN   = 3'd4,
    PAUSE  = 3'd5,
    FINISH = 3'd6
  } state_t;

  // Indexed by mode; element 0 is the rightmost entry.
  localparam logic [3:0][4:0] PRICE     = {5'd8,  5'd15, 5'd10, 5'd5};
  localparam logic [3:0][4:0] DUR_WASH  = {5'd15, 5'd30, 5'd20, 5'd10};
  localparam logic [3:0][4:0] DUR_RINSE = {5'd10, 5'd15, 5'd10, 5'd5};
  localparam logic [3:0][4:0] DUR_SPIN  = {5'd0,  5'd15, 5'd10, 5'd5};

  // Cost never exceeds 15+31, so two BCD digits carry the value.
  function automatic logic [11:0] bin2bcd(input logic [5:0] v);
    return {4'd0, 4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

endpackage

// File: rtl/bcd_sub3.sv
// Three-digit BCD subtractor a-b; borrow set when b > a.
module bcd_sub3 (
  input  logic [11:0] a,
  input  logic [11:0] b,
  output logic [11:0] diff,
  output logic        borrow
);

  logic [3:0] bw;

  assign bw[0] = 1'b0;

  for (genvar i = 0; i < 3; i++) begin : g_dig
    logic [4:0] raw;
    assign raw               = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'd0, bw[i]};
    assign bw[i+1]           = raw[4];
    assign diff[4*i +: 4]    = raw[4] ? 4'(raw + 5'd10) : raw[3:0];
  end

  assign borrow = bw[3];

endmodule

// File: rtl/wash_seq.sv
// Washing-machine cycle sequencer with BCD pay-per-cycle balance.
// Optional WASH_SEQ_REFUND_EN: stop during WASH restores the paid balance.
module wash_seq
  import wash_pkg::*;
#(
  parameter int TICK_DIV   = 100000000,
  parameter int MAX_WEIGHT = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [4:0]  weight,
  input  logic [11:0] bal_in,
  input  logic        lid_open,
  input  logic        pause_btn,
  input  logic        stop_btn,
  output logic        busy,
  output logic [2:0]  phase,
  output logic [9:0]  remain_s,
  output logic [11:0] bal_out,
  output logic        done,
  output logic        err_funds,
  output logic        motor_on,
  output logic        water_in,
  output logic        drain
);

  localparam int PW = $clog2(TICK_DIV + 1);

  state_t        state, nxt, saved;
  logic [PW-1:0] presc;
  logic [1:0]    mode_l;
  logic [4:0]    weight_l;
  logic [11:0]   bal_l;
  logic          pause_flag;
  logic [5:0]    cost;
  logic [11:0]   cost_bcd, diff;
  logic          borrow, reject, tick, load, run, running;
  logic [9:0]    load_val, dw, dr, ds;

  assign cost     = 6'(PRICE[mode_l]) + 6'(weight_l);
  assign cost_bcd = bin2bcd(cost);
  assign reject   = borrow || (int'(weight_l) > MAX_WEIGHT);
  assign dw       = 10'(DUR_WASH[mode_l]) + 10'(weight_l);
  assign dr       = 10'(DUR_RINSE[mode_l]);
  assign ds       = 10'(DUR_SPIN[mode_l]);
  assign tick     = (presc == PW'(TICK_DIV - 1));
  assign running  = (state == WASH) || (state == RINSE) || (state == SPIN);

  bcd_sub3 u_sub (.a(bal_l), .b(cost_bcd), .diff(diff), .borrow(borrow));

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= nxt;

  always_comb begin
    nxt      = state;
    load     = 1'b0;
    load_val = '0;
    run      = 1'b0;
    case (state)
      IDLE:  if (start) nxt = CHECK;
      CHECK: if (reject) nxt = IDLE;
             else begin nxt = WASH; load = 1'b1; load_val = dw; end
      WASH, RINSE, SPIN: begin
        if (lid_open || pause_btn) nxt = PAUSE;
        else begin
          run = 1'b1;
          // Last tick of a phase: move on, skipping any zero-length phase.
          if (tick && remain_s == 10'd1) begin
            load = 1'b1;
            if (state == WASH && dr != 10'd0) begin
              nxt = RINSE; load_val = dr;
            end else if (state != SPIN && ds != 10'd0) begin
              nxt = SPIN; load_val = ds;
            end else nxt = FINISH;
          end
        end
      end
      PAUSE:  if (!lid_open && !pause_flag) nxt = saved;
      FINISH: begin nxt = IDLE; load = 1'b1; end
      default: nxt = IDLE;
    endcase
    if (stop_btn && state != IDLE) begin
      nxt = IDLE; load = 1'b1; load_val = '0; run = 1'b0;
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    phase     = state;
    done      = (state == FINISH);
    err_funds = (state == CHECK) && reject;
    motor_on  = running;
    drain     = (state == SPIN);
    water_in  = ((state == WASH)  && (remain_s > (dw >> 1))) ||
                ((state == RINSE) && (remain_s > (dr >> 1)));
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      presc      <= '0;
      remain_s   <= '0;
      bal_out    <= '0;
      pause_flag <= 1'b0;
      saved      <= IDLE;
      mode_l     <= '0;
      weight_l   <= '0;
      bal_l      <= '0;
    end else begin
      if (state == IDLE && start) begin
        mode_l   <= mode;
        weight_l <= weight;
        bal_l    <= bal_in;
      end
      if (load) begin
        remain_s <= load_val;
        presc    <= '0;
      end else if (run) begin
        if (tick) begin
          presc    <= '0;
          remain_s <= remain_s - 10'd1;
        end else presc <= presc + 1'b1;
      end
      if (state == CHECK && !reject) bal_out <= diff;
      if (running && nxt == PAUSE) saved <= state;
      if (pause_btn && (running || state == PAUSE)) pause_flag <= ~pause_flag;
      if (stop_btn && state != IDLE) begin
        pause_flag <= 1'b0;
`ifdef WASH_SEQ_REFUND_EN
        if (state == WASH) bal_out <= bal_l;
`endif
      end
    end

endmodule

// File: tb/tb_wash_seq.sv
// Scoreboard bench for wash_seq with TICK_DIV=4 (one tick every 4 clocks).
module tb_wash_seq;

  logic        clk = 1'b0, rst, start, lid_open, pause_btn, stop_btn;
  logic [1:0]  mode;
  logic [4:0]  weight;
  logic [11:0] bal_in;
  logic        busy, done, err_funds, motor_on, water_in, drain;
  logic [2:0]  phase;
  logic [9:0]  remain_s;
  logic [11:0] bal_out;

  wash_seq #(.TICK_DIV(4), .MAX_WEIGHT(20)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .weight(weight),
    .bal_in(bal_in), .lid_open(lid_open), .pause_btn(pause_btn),
    .stop_btn(stop_btn), .busy(busy), .phase(phase), .remain_s(remain_s),
    .bal_out(bal_out), .done(done), .err_funds(err_funds),
    .motor_on(motor_on), .water_in(water_in), .drain(drain)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bal;
    logic        err;
    int          cycles;
    int          rw, rr, rs;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, errors = 0;
  logic [11:0] model_bal = 12'h000;

  function automatic int price(int m);
    case (m) 0: return 5; 1: return 10; 2: return 15; default: return 8; endcase
  endfunction
  function automatic int dwash(int m);
    case (m) 0: return 10; 1: return 20; 2: return 30; default: return 15; endcase
  endfunction
  function automatic int drinse(int m);
    case (m) 0: return 5; 1: return 10; 2: return 15; default: return 10; endcase
  endfunction
  function automatic int dspin(int m);
    case (m) 0: return 5; 1: return 10; 2: return 15; default: return 0; endcase
  endfunction
  function automatic logic [11:0] int2bcd(int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  function automatic int bcd2int(logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives a start pulse and pushes the expected outcome; returns in CHECK.
  task automatic start_cycle(input int m, input int w, input logic [11:0] b);
    exp_t e;
    int   cost, bi;
    cost     = price(m) + w;
    bi       = bcd2int(b);
    e.rw     = dwash(m) + w;
    e.rr     = drinse(m);
    e.rs     = dspin(m);
    e.cycles = 1 + 4 * (e.rw + e.rr + e.rs);
    if (w > 20 || cost > bi) begin
      e.err = 1'b1; e.bal = model_bal;
    end else begin
      e.err = 1'b0; e.bal = int2bcd(bi - cost); model_bal = e.bal;
    end
    sb.push_back(e);
    mode = 2'(m); weight = 5'(w); bal_in = b; start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 0; mode = 0; weight = 0; bal_in = 0;
    lid_open = 0; pause_btn = 0; stop_btn = 0;
    #3;
    checks++;
    if ({busy, phase, remain_s, bal_out, done, err_funds, motor_on, water_in, drain} !== '0) begin
      errors++; $display("FAIL reset_outputs: got busy=%b phase=%0d remain=%0d bal=%h exp all zero",
                         busy, phase, remain_s, bal_out);
    end
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  // Full cycle; also used for the skipped-spin case.
  task automatic test_full(input int m, input int w, input logic [11:0] b);
    exp_t e;
    int   cnt = 0, rw = -1, rr = -1, rs = -1;
    logic [2:0] prev;
    logic wash_ok = 1'b0, spin_ok = 1'b1, order_ok = 1'b1;
    start_cycle(m, w, b);
    e = sb.pop_front();
    checks++;
    if (phase !== 3'd1 || err_funds !== 1'b0) begin
      errors++; $display("FAIL check_phase: got phase=%0d err=%b exp 1/0", phase, err_funds);
    end
    prev = phase;
    while (done !== 1'b1 && cnt < 2000) begin
      step(1);
      cnt++;
      if (phase != prev) begin
        if (phase == 3'd2) begin
          rw = int'(remain_s); wash_ok = water_in & motor_on & ~drain;
        end
        if (phase == 3'd3) rr = int'(remain_s);
        if (phase == 3'd4) begin
          rs = int'(remain_s); spin_ok = drain & motor_on & ~water_in;
        end
        if (phase == 3'd6 && prev != (e.rs == 0 ? 3'd3 : 3'd4)) order_ok = 1'b0;
        prev = phase;
      end
    end
    checks++;
    if (cnt !== e.cycles) begin
      errors++; $display("FAIL cycle_len: got %0d exp %0d", cnt, e.cycles);
    end
    checks++;
    if (bal_out !== e.bal) begin
      errors++; $display("FAIL bal_after_check: got %h exp %h", bal_out, e.bal);
    end
    checks++;
    if (rw !== e.rw || rr !== e.rr || rs !== (e.rs == 0 ? -1 : e.rs)) begin
      errors++; $display("FAIL phase_durations: got %0d/%0d/%0d exp %0d/%0d/%0d",
                         rw, rr, rs, e.rw, e.rr, e.rs);
    end
    checks++;
    if (!wash_ok || !spin_ok || !order_ok) begin
      errors++; $display("FAIL phase_outputs: got wash=%b spin=%b order=%b exp 1/1/1",
                         wash_ok, spin_ok, order_ok);
    end
    step(1);
    checks++;
    if ({done, busy, remain_s} !== '0 || bal_out !== e.bal) begin
      errors++; $display("FAIL after_done: got done=%b busy=%b remain=%0d bal=%h exp 0/0/0/%h",
                         done, busy, remain_s, bal_out, e.bal);
    end
  endtask

  task automatic test_reject(input int m, input int w, input logic [11:0] b);
    exp_t e;
    start_cycle(m, w, b);
    e = sb.pop_front();
    checks++;
    if (err_funds !== e.err) begin
      errors++; $display("FAIL err_funds_pulse: got %b exp %b", err_funds, e.err);
    end
    step(1);
    checks++;
    if (phase !== 3'd0 || err_funds !== 1'b0 || bal_out !== e.bal) begin
      errors++; $display("FAIL reject_idle: got phase=%0d err=%b bal=%h exp 0/0/%h",
                         phase, err_funds, bal_out, e.bal);
    end
  endtask

  task automatic wait_phase(input logic [2:0] p);
    int n = 0;
    while (phase !== p && n < 1000) begin step(1); n++; end
    checks++;
    if (phase !== p) begin
      errors++; $display("FAIL wait_phase: got %0d exp %0d", phase, p);
    end
  endtask

  task automatic test_pause_stop;
    exp_t        e;
    logic [9:0]  r0;
    logic [11:0] paid;
    paid = 12'h099;
    start_cycle(0, 10, paid);
    e = sb.pop_front();
    wait_phase(3'd2);
    step(10);
    lid_open = 1'b1;
    r0 = remain_s;
    step(1);
    checks++;
    if (phase !== 3'd5 || remain_s !== r0 || motor_on !== 1'b0 || water_in !== 1'b0) begin
      errors++; $display("FAIL lid_pause: got phase=%0d remain=%0d motor=%b exp 5/%0d/0",
                         phase, remain_s, motor_on, r0);
    end
    step(19);
    lid_open = 1'b0;
    checks++;
    if (phase !== 3'd5 || remain_s !== r0) begin
      errors++; $display("FAIL lid_frozen: got phase=%0d remain=%0d exp 5/%0d", phase, remain_s, r0);
    end
    step(1);
    checks++;
    if (phase !== 3'd2 || remain_s !== r0) begin
      errors++; $display("FAIL lid_resume: got phase=%0d remain=%0d exp 2/%0d", phase, remain_s, r0);
    end
    pause_btn = 1'b1; step(1); pause_btn = 1'b0;
    r0 = remain_s;
    step(5);
    checks++;
    if (phase !== 3'd5 || remain_s !== r0) begin
      errors++; $display("FAIL btn_pause: got phase=%0d remain=%0d exp 5/%0d", phase, remain_s, r0);
    end
    pause_btn = 1'b1; step(1); pause_btn = 1'b0;
    step(1);
    checks++;
    if (phase !== 3'd2 || remain_s !== r0 || bal_out !== e.bal) begin
      errors++; $display("FAIL btn_resume: got phase=%0d remain=%0d bal=%h exp 2/%0d/%h",
                         phase, remain_s, bal_out, r0, e.bal);
    end
    stop_btn = 1'b1; step(1); stop_btn = 1'b0;
`ifdef WASH_SEQ_REFUND_EN
    model_bal = paid;
`endif
    checks++;
    if (phase !== 3'd0 || busy !== 1'b0 || remain_s !== 10'd0 || bal_out !== model_bal) begin
      errors++; $display("FAIL stop_wash: got phase=%0d busy=%b remain=%0d bal=%h exp 0/0/0/%h",
                         phase, busy, remain_s, bal_out, model_bal);
    end
  endtask

  task automatic test_rst_spin;
    exp_t e;
    start_cycle(1, 0, 12'h050);
    e = sb.pop_front();
    wait_phase(3'd4);
    step(3);
    checks++;
    if (bal_out !== e.bal || drain !== 1'b1) begin
      errors++; $display("FAIL spin_state: got bal=%h drain=%b exp %h/1", bal_out, drain, e.bal);
    end
    rst = 1'b1;
    #2;
    model_bal = 12'h000;
    checks++;
    if ({busy, phase, remain_s, bal_out, done, err_funds, motor_on, water_in, drain} !== '0) begin
      errors++; $display("FAIL rst_mid_spin: got busy=%b phase=%0d remain=%0d bal=%h exp all zero",
                         busy, phase, remain_s, bal_out);
    end
    step(1);
    rst = 1'b0;
    step(1);
  endtask

  initial begin
    test_reset();
    test_full(1, 5, 12'h050);
    test_reject(2, 20, 12'h034);
    test_reject(0, 21, 12'h999);
    test_full(3, 0, 12'h008);
    test_pause_stop();
    test_rst_spin();
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d exp 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
